// File: rtl/mem_arb_pkg.sv
// Shared defaults and FSM state encoding for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RWAIT  = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin pick with the last-served register.
module mem_rr_arb
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       take,
    output logic       grant
);

    logic last;

    // On contention the requester not served last wins; otherwise the sole valid one.
    always_comb begin
        grant = 1'b0;
        if (valid == 2'b11) begin
            grant = ~last;
        end else if (valid[1]) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (take) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory with one-cycle read latency.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req0_ack,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req1_ack,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output state_t            dbg_state
);

    // Handshake: reqN_valid rises with we/addr/wdata and holds them stable until
    // the one-cycle reqN_ack pulse; valid is sampled only while the FSM is IDLE.

    state_t state;
    logic   win;
    logic   we_q;
    logic   grant;
    logic   take;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign take      = (state == ST_IDLE) && (req0_valid || req1_valid);
    assign sel_we    = grant ? req1_we    : req0_we;
    assign sel_addr  = grant ? req1_addr  : req0_addr;
    assign sel_wdata = grant ? req1_wdata : req0_wdata;
    assign dbg_state = state;

    mem_rr_arb u_rr (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .take  (take),
        .grant (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            win         <= 1'b0;
            we_q        <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            req0_ack    <= 1'b0;
            req1_ack    <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        win         <= grant;
                        we_q        <= sel_we;
                        mem_addr    <= sel_addr;
                        mem_data_in <= sel_wdata;
                        mem_write   <= sel_we;
                        mem_read    <= ~sel_we;
                        busy        <= 1'b1;
                        state       <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    if (we_q) begin
                        req0_ack <= ~win;
                        req1_ack <= win;
                        state    <= ST_ACK;
                    end else begin
                        state <= ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    if (win) begin
                        req1_rdata <= mem_data_out;
                    end else begin
                        req0_rdata <= mem_data_out;
                    end
                    req0_ack <= ~win;
                    req1_ack <= win;
                    state    <= ST_ACK;
                end
                ST_ACK: begin
                    req0_ack <= 1'b0;
                    req1_ack <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 32x8 memory behind it.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_we, req1_valid, req1_we;
    logic [4:0] req0_addr, req1_addr;
    logic [7:0] req0_wdata, req1_wdata;
    logic       req0_ack, req1_ack;
    logic [7:0] req0_rdata, req1_rdata;
    logic       mem_read, mem_write;
    logic [4:0] mem_addr;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;
    logic       busy;
    state_t     dbg_state;

    logic [7:0] mem [32];

    int checks = 0;
    int errors = 0;

    // clock / reset
    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_we      (req0_we),
        .req0_addr    (req0_addr),
        .req0_wdata   (req0_wdata),
        .req1_valid   (req1_valid),
        .req1_we      (req1_we),
        .req1_addr    (req1_addr),
        .req1_wdata   (req1_wdata),
        .req0_ack     (req0_ack),
        .req0_rdata   (req0_rdata),
        .req1_ack     (req1_ack),
        .req1_rdata   (req1_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // memory model: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_data_in;
        if (mem_read) mem_data_out <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd"},   32'(mem_read),    32'd0);
        check({tag, "_wr"},   32'(mem_write),   32'd0);
        check({tag, "_addr"}, 32'(mem_addr),    32'd0);
        check({tag, "_din"},  32'(mem_data_in), 32'd0);
        check({tag, "_ack0"}, 32'(req0_ack),    32'd0);
        check({tag, "_ack1"}, 32'(req1_ack),    32'd0);
        check({tag, "_rd0"},  32'(req0_rdata),  32'd0);
        check({tag, "_rd1"},  32'(req1_rdata),  32'd0);
        check({tag, "_busy"}, 32'(busy),        32'd0);
        check({tag, "_st"},   32'(dbg_state),   32'(ST_IDLE));
    endtask

    initial begin
        logic [4:0] rd_addr [4];
        logic [7:0] rd_data [4];
        int         idx;

        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem_data_out = 8'h00;
        rst = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // req0 write addr 5 = A5
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 5'd5; req0_wdata = 8'hA5;
        tick();
        check("w_c1_wr",   32'(mem_write),   32'd1);
        check("w_c1_rd",   32'(mem_read),    32'd0);
        check("w_c1_addr", 32'(mem_addr),    32'd5);
        check("w_c1_din",  32'(mem_data_in), 32'hA5);
        check("w_c1_busy", 32'(busy),        32'd1);
        check("w_c1_ack0", 32'(req0_ack),    32'd0);
        tick();
        check("w_c2_ack0", 32'(req0_ack),    32'd1);
        check("w_c2_ack1", 32'(req1_ack),    32'd0);
        check("w_c2_wr",   32'(mem_write),   32'd0);
        req0_valid = 1'b0;
        tick();
        check("w_c3_ack0", 32'(req0_ack),    32'd0);
        check("w_c3_busy", 32'(busy),        32'd0);
        check("w_c3_addr", 32'(mem_addr),    32'd5);

        // req1 read addr 5
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 5'd5;
        tick();
        check("r_c1_rd",   32'(mem_read),  32'd1);
        check("r_c1_wr",   32'(mem_write), 32'd0);
        tick();
        check("r_c2_st",   32'(dbg_state), 32'(ST_RWAIT));
        check("r_c2_rd",   32'(mem_read),  32'd0);
        check("r_c2_ack1", 32'(req1_ack),  32'd0);
        tick();
        check("r_c3_ack1", 32'(req1_ack),   32'd1);
        check("r_c3_ack0", 32'(req0_ack),   32'd0);
        check("r_c3_rd1",  32'(req1_rdata), 32'hA5);
        check("r_c3_rd0",  32'(req0_rdata), 32'h00);
        req1_valid = 1'b0;
        tick();

        // contention, both writing, held: grants 0,1,0,1 every 3 cycles
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 5'd10; req0_wdata = 8'h11;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 5'd12; req1_wdata = 8'h22;
        for (int c = 1; c <= 11; c++) begin
            tick();
            check($sformatf("rr_c%0d_ack0", c), 32'(req0_ack), 32'((c == 2) || (c == 8)));
            check($sformatf("rr_c%0d_ack1", c), 32'(req1_ack), 32'((c == 5) || (c == 11)));
            if (c == 1 || c == 7) check($sformatf("rr_c%0d_addr", c), 32'(mem_addr), 32'd10);
            if (c == 4 || c == 10) check($sformatf("rr_c%0d_addr", c), 32'(mem_addr), 32'd12);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("rr_end_busy", 32'(busy), 32'd0);

        // top address write then read
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 5'd31; req0_wdata = 8'hFF;
        tick();
        check("top_w_addr", 32'(mem_addr), 32'd31);
        tick();
        check("top_w_ack", 32'(req0_ack), 32'd1);
        req0_valid = 1'b0;
        tick();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 5'd31;
        tick();
        check("top_r_addr", 32'(mem_addr), 32'd31);
        check("top_r_rd",   32'(mem_read), 32'd1);
        tick(); tick();
        check("top_r_ack",  32'(req0_ack),   32'd1);
        check("top_r_data", 32'(req0_rdata), 32'hFF);
        req0_valid = 1'b0;
        tick();

        // reset during RWAIT aborts the read
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 5'd31;
        tick();
        tick();
        check("abort_st", 32'(dbg_state), 32'(ST_RWAIT));
        rst = 1'b1;
        req1_valid = 1'b0;
        tick();
        check_all_zero("abort");
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("abort_noack%0d", c), 32'(req1_ack), 32'd0);
        end

        // single requester, four back-to-back reads every 4 cycles
        rd_addr[0] = 5'd5;  rd_data[0] = 8'hA5;
        rd_addr[1] = 5'd31; rd_data[1] = 8'hFF;
        rd_addr[2] = 5'd12; rd_data[2] = 8'h22;
        rd_addr[3] = 5'd10; rd_data[3] = 8'h11;
        idx = 0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = rd_addr[0];
        for (int c = 1; c <= 15; c++) begin
            tick();
            check($sformatf("seq_c%0d_ack0", c), 32'(req0_ack), 32'd0);
            check($sformatf("seq_c%0d_ack1", c), 32'(req1_ack), 32'((c % 4) == 3));
            if ((c % 4) == 3) begin
                check($sformatf("seq_rd%0d", idx), 32'(req1_rdata), 32'(rd_data[idx]));
                idx++;
                if (idx < 4) req1_addr = rd_addr[idx];
                else req1_valid = 1'b0;
            end
        end
        check("seq_count", 32'(idx), 32'd4);
        tick();
        check("seq_end_busy", 32'(busy), 32'd0);
        check("seq_rd0_keep", 32'(req0_rdata), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
